// File: rtl/pulse_serial_deserialiser.sv
// -----------------------------------------------------------------------------
// pulse_serial_deserialiser
//
// Receive side of the pulse-triggered single-wire serialiser. It generates the
// periodic trigger that starts a serialiser frame, and it rebuilds the returned
// frame (WIDTH bits, MSB first, one bit per clk, valid_in marking the MSB)
// into a parallel word that is presented with a one-cycle strobe.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   trig_en     enables periodic trigger generation
//   trig_out    one-cycle trigger pulse every TRIG_PERIOD clk cycles
//   serial_in   serialised data bit
//   valid_in    first-bit marker, high only during the MSB cycle
//   data_out    last completed word, MSB = first received bit
//   data_valid  one-cycle strobe when data_out updates
//   frame_err   one-cycle strobe when a frame restarts before completing
//   frame_cnt   count of good frames, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module pulse_serial_deserialiser #(
   parameter int WIDTH       = 13,
   parameter int TRIG_PERIOD = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig_en,
   output logic             trig_out,
   input  logic             serial_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int              BC_W      = $clog2(WIDTH + 1);
   localparam logic [15:0]     TRIG_LAST = 16'(TRIG_PERIOD - 1);
   localparam logic [BC_W-1:0] BIT_ONE   = BC_W'(1);
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RECV = 1'b1;

   // ---------------------------------------------------------------------------
   // Trigger generator
   // ---------------------------------------------------------------------------
   logic [15:0] r_trig_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trig_cnt <= '0;
         trig_out   <= 1'b0;
      end else if (!trig_en) begin
         r_trig_cnt <= '0;
         trig_out   <= 1'b0;
      end else if (r_trig_cnt == TRIG_LAST) begin
         // Pulse is registered, so dropping trig_en while it is high cannot
         // cut it short.
         r_trig_cnt <= '0;
         trig_out   <= 1'b1;
      end else begin
         r_trig_cnt <= r_trig_cnt + 16'd1;
         trig_out   <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------------
   // The shift register only ever needs to hold WIDTH-1 bits: the final bit is
   // taken straight from serial_in when the word is committed to data_out.
   logic [0:0]       r_state;
   logic [WIDTH-2:0] r_shift;
   logic [BC_W-1:0]  r_bit_cnt;
   logic [WIDTH-1:0] w_word;
   logic             w_last;

   assign w_word = {r_shift, serial_in};
   assign w_last = (r_bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (valid_in) begin
                  r_shift   <= {{(WIDTH-2){1'b0}}, serial_in};
                  r_bit_cnt <= BIT_ONE;
                  r_state   <= S_RECV;
               end
            end
            default: begin
               if (valid_in) begin
                  // Premature restart: drop the partial word and treat this
                  // edge as the MSB of a new frame.
                  frame_err <= 1'b1;
                  r_shift   <= {{(WIDTH-2){1'b0}}, serial_in};
                  r_bit_cnt <= BIT_ONE;
               end else if (w_last) begin
                  data_out   <= w_word;
                  data_valid <= 1'b1;
                  frame_cnt  <= frame_cnt + CNT_W'(1);
                  r_bit_cnt  <= '0;
                  r_state    <= S_IDLE;
               end else begin
                  r_shift   <= w_word[WIDTH-2:0];
                  r_bit_cnt <= r_bit_cnt + BIT_ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_serial_deserialiser.sv
// -----------------------------------------------------------------------------
// tb_pulse_serial_deserialiser
//
// Self-checking bench: directed scenarios followed by random frames, every
// cycle compared against a frame-level reference model (bit queue plus a
// count of enabled cycles for the trigger).
// -----------------------------------------------------------------------------
module tb_pulse_serial_deserialiser;

   localparam int WIDTH       = 13;
   localparam int TRIG_PERIOD = 64;
   localparam int CNT_W       = 8;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             trig_en   = 1'b0;
   logic             serial_in = 1'b0;
   logic             valid_in  = 1'b0;
   logic             trig_out;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic [CNT_W-1:0] frame_cnt;

   pulse_serial_deserialiser #(
      .WIDTH       (WIDTH),
      .TRIG_PERIOD (TRIG_PERIOD),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .trig_en    (trig_en),
      .trig_out   (trig_out),
      .serial_in  (serial_in),
      .valid_in   (valid_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: frame bits collected in a queue, trigger from the number
   // of consecutive enabled clock edges.
   // ---------------------------------------------------------------------------
   bit               m_bits[$];
   int unsigned      en_run;
   logic [WIDTH-1:0] exp_data;
   bit               exp_dv, exp_err, exp_trig;
   int unsigned      exp_cnt;

   task automatic model_clear();
      m_bits.delete();
      en_run   = 0;
      exp_data = '0;
      exp_dv   = 0;
      exp_err  = 0;
      exp_trig = 0;
      exp_cnt  = 0;
   endtask

   task automatic model_edge(input bit v, input bit s, input bit en);
      int unsigned w;
      exp_dv  = 0;
      exp_err = 0;
      if (en) begin
         en_run++;
         exp_trig = ((en_run % TRIG_PERIOD) == 0);
      end else begin
         en_run   = 0;
         exp_trig = 0;
      end
      if (v) begin
         if (m_bits.size() > 0) exp_err = 1;
         m_bits.delete();
         m_bits.push_back(s);
      end else if (m_bits.size() > 0) begin
         m_bits.push_back(s);
      end
      if (m_bits.size() == WIDTH) begin
         w = 0;
         foreach (m_bits[i]) w = w * 2 + m_bits[i];
         exp_data = WIDTH'(w);
         exp_dv   = 1;
         exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
         m_bits.delete();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers: inputs change on the falling edge, outputs checked on
   // the next falling edge.
   // ---------------------------------------------------------------------------
   int n_dv   = 0;
   int n_err  = 0;
   int n_trig = 0;

   task automatic step(input bit v, input bit s);
      valid_in  = v;
      serial_in = s;
      if (!rst_n) model_clear();
      else        model_edge(v, s, trig_en);
      @(negedge clk);
      check_val("trig_out",   32'(trig_out),   32'(exp_trig));
      check_val("data_valid", 32'(data_valid), 32'(exp_dv));
      check_val("frame_err",  32'(frame_err),  32'(exp_err));
      check_val("data_out",   32'(data_out),   32'(exp_data));
      check_val("frame_cnt",  32'(frame_cnt),  exp_cnt);
      if (data_valid) n_dv++;
      if (frame_err)  n_err++;
      if (trig_out)   n_trig++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
   endtask

   task automatic send_bits(input logic [WIDTH-1:0] word, input int nbits);
      for (int i = 0; i < nbits; i++) step(i == 0, word[WIDTH-1-i]);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [WIDTH-1:0] loop_word;
      int               ser_idx;
      int               err_base;
      int               nb;

      model_clear();
      @(negedge clk);

      // Reset state
      idle(3);
      check_val("rst_data_out", 32'(data_out), 32'h0);
      check_val("rst_frame_cnt", 32'(frame_cnt), 32'h0);

      // Trigger timing: enabled from reset release, then disabled
      rst_n   = 1'b1;
      trig_en = 1'b1;
      n_trig  = 0;
      idle(200);
      trig_en = 1'b0;
      idle(100);
      check_val("trig_pulses", 32'(n_trig), 32'd3);

      // Single frame
      send_bits(13'h1A5B, WIDTH);
      idle(2);
      check_val("single_word", 32'(data_out), 32'h1A5B);
      check_val("single_cnt", 32'(frame_cnt), 32'd1);

      // Back-to-back frames
      err_base = n_err;
      send_bits(13'h0000, WIDTH);
      send_bits(13'h1FFF, WIDTH);
      send_bits(13'h0AAA, WIDTH);
      idle(2);
      check_val("b2b_word", 32'(data_out), 32'h0AAA);
      check_val("b2b_cnt", 32'(frame_cnt), 32'd4);
      check_val("b2b_errs", 32'(n_err - err_base), 32'd0);

      // Premature restart at bit 6
      err_base = n_err;
      send_bits(13'h1555, 6);
      send_bits(13'h0123, WIDTH);
      idle(2);
      check_val("restart_errs", 32'(n_err - err_base), 32'd1);
      check_val("restart_word", 32'(data_out), 32'h0123);
      check_val("restart_cnt", 32'(frame_cnt), 32'd5);

      // Loopback: a serialiser that starts a frame on each trigger pulse
      loop_word = 13'h1F00;
      ser_idx   = WIDTH;
      n_dv      = 0;
      trig_en   = 1'b1;
      for (int c = 0; c < 4 * TRIG_PERIOD + 20; c++) begin
         if (trig_out) ser_idx = 0;
         if (ser_idx < WIDTH) begin
            step(ser_idx == 0, loop_word[WIDTH-1-ser_idx]);
            ser_idx++;
         end else begin
            step(1'b0, 1'b0);
         end
      end
      trig_en = 1'b0;
      check_val("loop_frames", 32'(n_dv), 32'd4);
      check_val("loop_word", 32'(data_out), 32'h1F00);

      // Reset in the middle of a frame
      send_bits(13'h0F0F, 5);
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      check_val("midrst_data_out", 32'(data_out), 32'h0);
      check_val("midrst_cnt", 32'(frame_cnt), 32'h0);
      rst_n = 1'b1;
      idle(1);
      send_bits(13'h1234, WIDTH);
      idle(2);
      check_val("midrst_word", 32'(data_out), 32'h1234);
      check_val("midrst_next_cnt", 32'(frame_cnt), 32'd1);

      // Random frames, gaps, aborts and trigger toggling; enough good frames
      // to carry frame_cnt past its wrap point.
      for (int f = 0; f < 340; f++) begin
         if (($urandom % 16) == 0) trig_en = ~trig_en;
         idle($urandom_range(0, 3));
         nb = (($urandom % 8) == 0) ? $urandom_range(1, WIDTH - 1) : WIDTH;
         send_bits(WIDTH'($urandom), nb);
      end
      idle(WIDTH + 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
